hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline hazard and sequencing controller for the 5-stage MIPS core. It generates stall and flush controls for IF/ID/EX, covering load-use and branch-operand hazards that forwarding cannot resolve. It also sequences the multi-cycle MULT/DIV unit in EX through a busy/done state machine. It sits beside the EX-stage forwarding logic and drives the pipeline register enables and clears.

## Interface
Parameters:
- MULT_CYCLES, default 4: EX-unit occupancy for MULT/MULTU (must be ≥1).
- DIV_CYCLES, default 32: EX-unit occupancy for DIV/DIVU (must be ≥1).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rs_D, rt_D  in  5  source registers of the instruction in ID.
- Branch_D  in  1  ID holds a branch that compares registers in ID.
- branch_taken_D  in  1  branch resolved taken in ID.
- Jump_D  in  1  ID holds J/JAL/JR.
- hilo_use_D  in  1  ID holds MFHI/MFLO/MULT/DIV (needs HI/LO or the unit).
- RegWrite_E, MemtoReg_E  in  1  EX-stage write-enable and load flag.
- reg_write_addr_E  in  5  EX-stage destination.
- MemtoReg_M  in  1  MEM-stage load flag.
- reg_write_addr_M  in  5  MEM-stage destination.
- md_start_E  in  1  single-cycle pulse: MULT/DIV issued in EX.
- md_is_div_E  in  1  qualifies md_start_E (1 = divide).
- Stall_F, Stall_D  out  1  hold PC and the IF/ID register.
- Flush_D  out  1  clear the IF/ID register.
- Flush_E  out  1  clear the ID/EX register (bubble).
- md_busy  out  1  MULT/DIV unit occupied.
- md_done  out  1  one-cycle pulse: HI/LO write enable.
- md_overrun  out  1  sticky error: md_start_E arrived while BUSY.

## Operation
Write-address fields equal to 0 never create a hazard.

Stall terms:
- lw_stall = MemtoReg_E & RegWrite_E & (reg_write_addr_E matches rs_D or rt_D).
- br_stall = Branch_D & ((RegWrite_E & reg_write_addr_E matches rs_D/rt_D) | (MemtoReg_M & reg_write_addr_M matches rs_D/rt_D)).
- md_stall = hilo_use_D & (state == BUSY).

Combinational outputs:
- Stall_F = Stall_D = Flush_E = lw_stall | br_stall | md_stall.
- Flush_D = (branch_taken_D | Jump_D) & ~Stall_D. A redirect is never taken while ID is stalled.

MULT/DIV FSM states:
- IDLE: md_start_E → BUSY, and cnt loads (md_is_div_E ? DIV_CYCLES : MULT_CYCLES) − 1.
- BUSY: cnt decrements each cycle. When cnt == 0 → DONE. md_start_E here sets md_overrun and is otherwise ignored.
- DONE: md_done = 1. md_start_E → BUSY with reload (back-to-back issue); otherwise → IDLE.

Other rules:
- md_busy = (state == BUSY).
- cnt width = $clog2(max(MULT_CYCLES, DIV_CYCLES)) + 1. cnt never underflows.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, cnt = 0, md_overrun = 0, md_busy = 0, md_done = 0. Stall and flush outputs follow their combinational equations.
- Reset asserted mid-operation aborts a BUSY sequence; no md_done is produced.
- md_start_E sampled at edge k: md_busy is high for exactly N cycles after edge k, then md_done is high for the following cycle, where N = MULT_CYCLES or DIV_CYCLES.
- A hilo_use_D in the DONE cycle is not stalled; HI/LO is written at the end of that cycle.
- Stall and flush outputs have zero-cycle latency from their inputs. A hazard held for M cycles gives M stalls and M bubbles.
- If lw_stall and branch_taken_D occur in the same cycle: stall, Flush_D = 0. The redirect happens once the stall releases.

## Structure
- Shared package mips_pkg: state enum md_state_t {IDLE, BUSY, DONE}, and constants REG_ZERO = 5'd0 and the default cycle counts.
- One natural sub-module: md_sequencer (the FSM, counter and overrun flag). The hazard equations stay in the top module.

## Test plan
- lw $t0 in EX, add using $t0 in ID → one cycle with Stall_F = Stall_D = Flush_E = 1, then 0. Flush_D = 0 throughout.
- beq $t1 in ID, with $t1 written by an ALU op in EX → 1 stall cycle. With $t1 loaded by lw in MEM → 1 stall cycle. Then branch_taken_D = 1 gives Flush_D = 1 for one cycle.
- md_start_E, md_is_div_E = 1 with DIV_CYCLES = 32 → md_busy high for 32 cycles, md_done high on cycle 33. mflo in ID during BUSY stalls until the DONE cycle.
- MULT issued exactly in the DONE cycle → immediate re-entry to BUSY for 4 cycles with no IDLE gap. md_done pulses once per operation.
- md_start_E pulsed while BUSY → md_overrun = 1, and it remains 1 until rst_n is asserted low.
- rst_n asserted low in the 10th BUSY cycle of a divide → md_busy = 0 immediately. No md_done after release. The next md_start_E runs the full count.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
// Holds the MULT/DIV sequencer state encoding, the hard-wired zero register
// index, the default unit occupancies and a helper for hazard matching.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam logic [4:0]  REG_ZERO         = 5'd0;
  localparam int unsigned MULT_CYCLES_DEF  = 4;
  localparam int unsigned DIV_CYCLES_DEF   = 32;

  // True when a producer writing waddr feeds either ID source register.
  // Writes to $zero are discarded by the register file, so they never match.
  function automatic logic src_match(input logic [4:0] waddr,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt);
    return (waddr != REG_ZERO) && ((waddr == rs) || (waddr == rt));
  endfunction

endpackage

// File: rtl/md_sequencer.sv
// MULT/DIV unit sequencer.
// Tracks occupancy of the multi-cycle multiply/divide unit in EX.
//   clk, rst_n    : core clock, asynchronous active-low reset
//   md_start_i    : one-cycle issue pulse from EX
//   md_is_div_i   : qualifies md_start_i (1 = divide, 0 = multiply)
//   md_busy_o     : unit occupied
//   md_done_o     : one-cycle HI/LO write enable
//   md_overrun_o  : sticky, an issue arrived while the unit was busy
module md_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start_i,
  input  logic md_is_div_i,
  output logic md_busy_o,
  output logic md_done_o,
  output logic md_overrun_o
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  // The counter holds the number of BUSY cycles still to come after this one,
  // so an N-cycle operation loads N-1 and leaves BUSY on reaching zero.
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

  md_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            overrun_q, overrun_d;
  logic [CntW-1:0] load_val;

  assign load_val = md_is_div_i ? DivLoad : MultLoad;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q | (md_start_i & (state_q == BUSY));

    unique case (state_q)
      IDLE: begin
        if (md_start_i) begin
          state_d = BUSY;
          cnt_d   = load_val;
        end
      end
      BUSY: begin
        // Issues during BUSY are only recorded as overrun, never queued.
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      DONE: begin
        // Back-to-back issue skips IDLE entirely.
        if (md_start_i) begin
          state_d = BUSY;
          cnt_d   = load_val;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign md_busy_o    = (state_q == BUSY);
  assign md_done_o    = (state_q == DONE);
  assign md_overrun_o = overrun_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard and sequencing controller for the 5-stage MIPS core.
// Produces stall/flush controls for IF/ID/EX covering load-use and
// branch-operand hazards that forwarding cannot resolve, and sequences the
// multi-cycle MULT/DIV unit.
//   clk, rst_n                      : core clock, asynchronous active-low reset
//   rs_D, rt_D                      : ID source registers
//   Branch_D, branch_taken_D        : ID compare-branch and its resolution
//   Jump_D                          : ID holds J/JAL/JR
//   hilo_use_D                      : ID needs HI/LO or the MULT/DIV unit
//   RegWrite_E, MemtoReg_E          : EX write-enable and load flag
//   reg_write_addr_E                : EX destination
//   MemtoReg_M, reg_write_addr_M    : MEM load flag and destination
//   md_start_E, md_is_div_E         : MULT/DIV issue pulse and kind
//   Stall_F, Stall_D                : hold PC and IF/ID
//   Flush_D, Flush_E                : clear IF/ID, bubble ID/EX
//   md_busy, md_done, md_overrun    : MULT/DIV unit status
module hazard_controller
  import mips_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic       Branch_D,
  input  logic       branch_taken_D,
  input  logic       Jump_D,
  input  logic       hilo_use_D,
  input  logic       RegWrite_E,
  input  logic       MemtoReg_E,
  input  logic [4:0] reg_write_addr_E,
  input  logic       MemtoReg_M,
  input  logic [4:0] reg_write_addr_M,
  input  logic       md_start_E,
  input  logic       md_is_div_E,
  output logic       Stall_F,
  output logic       Stall_D,
  output logic       Flush_D,
  output logic       Flush_E,
  output logic       md_busy,
  output logic       md_done,
  output logic       md_overrun
);

  logic lw_stall;
  logic br_stall;
  logic md_stall;
  logic stall;
  logic e_match;
  logic m_match;

  md_sequencer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_sequencer (
    .clk          (clk),
    .rst_n        (rst_n),
    .md_start_i   (md_start_E),
    .md_is_div_i  (md_is_div_E),
    .md_busy_o    (md_busy),
    .md_done_o    (md_done),
    .md_overrun_o (md_overrun)
  );

  assign e_match = src_match(reg_write_addr_E, rs_D, rt_D);
  assign m_match = src_match(reg_write_addr_M, rs_D, rt_D);

  // Load result is not available until MEM ends, so a consumer in ID waits.
  assign lw_stall = MemtoReg_E & RegWrite_E & e_match;

  // Branches compare in ID, earlier than the EX forwarding path, so any EX
  // producer or a MEM load feeding the comparison must be waited out.
  assign br_stall = Branch_D & ((RegWrite_E & e_match) | (MemtoReg_M & m_match));

  // HI/LO is written at the end of the DONE cycle, so only BUSY blocks.
  assign md_stall = hilo_use_D & md_busy;

  assign stall   = lw_stall | br_stall | md_stall;
  assign Stall_F = stall;
  assign Stall_D = stall;
  assign Flush_E = stall;

  // A stalled ID instruction will be re-presented, so its redirect waits.
  assign Flush_D = (branch_taken_D | Jump_D) & ~stall;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

  localparam int MULT_N = 4;
  localparam int DIV_N  = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_D, rt_D, reg_write_addr_E, reg_write_addr_M;
  logic       Branch_D, branch_taken_D, Jump_D, hilo_use_D;
  logic       RegWrite_E, MemtoReg_E, MemtoReg_M, md_start_E, md_is_div_E;
  logic       Stall_F, Stall_D, Flush_D, Flush_E, md_busy, md_done, md_overrun;

  int total = 0;
  int bad   = 0;

  hazard_controller #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rs_D             (rs_D),
    .rt_D             (rt_D),
    .Branch_D         (Branch_D),
    .branch_taken_D   (branch_taken_D),
    .Jump_D           (Jump_D),
    .hilo_use_D       (hilo_use_D),
    .RegWrite_E       (RegWrite_E),
    .MemtoReg_E       (MemtoReg_E),
    .reg_write_addr_E (reg_write_addr_E),
    .MemtoReg_M       (MemtoReg_M),
    .reg_write_addr_M (reg_write_addr_M),
    .md_start_E       (md_start_E),
    .md_is_div_E      (md_is_div_E),
    .Stall_F          (Stall_F),
    .Stall_D          (Stall_D),
    .Flush_D          (Flush_D),
    .Flush_E          (Flush_E),
    .md_busy          (md_busy),
    .md_done          (md_done),
    .md_overrun       (md_overrun)
  );

  always #5 clk = ~clk;

  // Reference model: the unit is described by its occupancy window in
  // absolute cycle numbers; cycle c is the period following rising edge c.
  int cyc    = 0;
  int win_lo = -100;
  int win_hi = -100;
  bit m_ovr  = 1'b0;

  function automatic bit m_busy();
    return (cyc >= win_lo) && (cyc <= win_hi);
  endfunction

  function automatic bit m_done();
    return cyc == win_hi + 1;
  endfunction

  function automatic bit m_stall();
    bit lw, br, e_hit, m_hit;
    e_hit = (reg_write_addr_E != 0) && (reg_write_addr_E == rs_D || reg_write_addr_E == rt_D);
    m_hit = (reg_write_addr_M != 0) && (reg_write_addr_M == rs_D || reg_write_addr_M == rt_D);
    lw = MemtoReg_E && RegWrite_E && e_hit;
    br = Branch_D && ((RegWrite_E && e_hit) || (MemtoReg_M && m_hit));
    return lw || br || (hilo_use_D && m_busy());
  endfunction

  function automatic void model_reset();
    win_lo = -100;
    win_hi = -100;
    m_ovr  = 1'b0;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Checks every output against the model mid-cycle, then advances one edge.
  task automatic step();
    bit s;
    @(negedge clk);
    s = m_stall();
    check("stall_f", Stall_F, s);
    check("stall_d", Stall_D, s);
    check("flush_e", Flush_E, s);
    check("flush_d", Flush_D, (branch_taken_D | Jump_D) & ~s);
    check("busy", md_busy, m_busy());
    check("done", md_done, m_done());
    check("overrun", md_overrun, m_ovr);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (md_start_E) begin
      if (m_busy()) begin
        m_ovr = 1'b1;
      end else begin
        win_lo = cyc + 1;
        win_hi = cyc + (md_is_div_E ? DIV_N : MULT_N);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic clear_inputs();
    rs_D = 0; rt_D = 0; reg_write_addr_E = 0; reg_write_addr_M = 0;
    Branch_D = 0; branch_taken_D = 0; Jump_D = 0; hilo_use_D = 0;
    RegWrite_E = 0; MemtoReg_E = 0; MemtoReg_M = 0; md_start_E = 0; md_is_div_E = 0;
  endtask

  // Pulse reset across one edge, leaving time at 1 after a rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [4:0] rs, rt;
    logic       br, tk, jp;
    logic       rwe, mte;
    logic [4:0] wae;
    logic       mtm;
    logic [4:0] wam;
    logic       st, fd;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int nbusy, ndone, done_at, waited;
    bit found;

    clear_inputs();
    rst_n = 1'b0;
    #1;
    check("reset_busy", md_busy, 1'b0);
    check("reset_done", md_done, 1'b0);
    check("reset_ovr", md_overrun, 1'b0);
    check("reset_stall", Stall_D, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    //          rs  rt  br tk jp rwe mte wae mtm wam  st fd
    vecs[0]  = '{8,  9,  0, 0, 0, 1, 1, 10, 0, 0,  0, 0};
    vecs[1]  = '{8,  9,  0, 0, 0, 1, 1, 8,  0, 0,  1, 0};
    vecs[2]  = '{8,  9,  0, 0, 0, 1, 1, 9,  0, 0,  1, 0};
    vecs[3]  = '{0,  9,  0, 0, 0, 1, 1, 0,  0, 0,  0, 0};
    vecs[4]  = '{8,  9,  0, 0, 0, 0, 1, 8,  0, 0,  0, 0};
    vecs[5]  = '{9,  3,  1, 0, 0, 1, 0, 9,  0, 0,  1, 0};
    vecs[6]  = '{9,  3,  0, 0, 0, 1, 0, 9,  0, 0,  0, 0};
    vecs[7]  = '{4,  9,  1, 0, 0, 0, 0, 0,  1, 9,  1, 0};
    vecs[8]  = '{4,  9,  0, 0, 0, 0, 0, 0,  1, 9,  0, 0};
    vecs[9]  = '{4,  9,  1, 1, 0, 0, 0, 0,  0, 9,  0, 1};
    vecs[10] = '{4,  9,  0, 0, 1, 0, 0, 0,  0, 0,  0, 1};
    vecs[11] = '{8,  9,  1, 1, 0, 1, 1, 8,  0, 0,  1, 0};
    vecs[12] = '{0,  3,  1, 0, 0, 1, 0, 0,  0, 0,  0, 0};
    vecs[13] = '{0,  3,  1, 1, 0, 0, 0, 0,  1, 0,  0, 1};
    vecs[14] = '{5,  9,  1, 0, 0, 1, 0, 7,  1, 5,  1, 0};

    for (int i = 0; i < 15; i++) begin
      rs_D = vecs[i].rs; rt_D = vecs[i].rt;
      Branch_D = vecs[i].br; branch_taken_D = vecs[i].tk; Jump_D = vecs[i].jp;
      RegWrite_E = vecs[i].rwe; MemtoReg_E = vecs[i].mte; reg_write_addr_E = vecs[i].wae;
      MemtoReg_M = vecs[i].mtm; reg_write_addr_M = vecs[i].wam;
      #1;
      check($sformatf("vec%0d_stall_f", i), Stall_F, vecs[i].st);
      check($sformatf("vec%0d_stall_d", i), Stall_D, vecs[i].st);
      check($sformatf("vec%0d_flush_e", i), Flush_E, vecs[i].st);
      check($sformatf("vec%0d_flush_d", i), Flush_D, vecs[i].fd);
    end
    clear_inputs();
    step();

    // Divide with mflo waiting in ID.
    hilo_use_D = 1; md_start_E = 1; md_is_div_E = 1;
    step();
    md_start_E = 0;
    nbusy = 0; done_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (md_busy) nbusy++;
      if (md_done && done_at < 0) begin
        done_at = i;
        check("div_done_no_stall", Stall_D, 1'b0);
      end
      step();
    end
    check_int("div_busy_len", nbusy, DIV_N);
    check_int("div_done_at", done_at, DIV_N);
    hilo_use_D = 0;

    // Multiply re-issued exactly in the DONE cycle.
    md_start_E = 1; md_is_div_E = 0;
    step();
    md_start_E = 0;
    ndone = 0; found = 0; waited = 0;
    while (!found && waited < 10) begin
      if (md_done) found = 1;
      else begin
        step();
        waited++;
      end
    end
    check("b2b_first_done_seen", found, 1'b1);
    ndone = found ? 1 : 0;
    md_start_E = 1;
    step();
    md_start_E = 0;
    nbusy = 0; done_at = -1;
    for (int i = 0; i < 8; i++) begin
      if (md_busy) nbusy++;
      if (md_done) begin
        ndone++;
        if (done_at < 0) done_at = i;
      end
      step();
    end
    check_int("b2b_busy_len", nbusy, MULT_N);
    check_int("b2b_done_at", done_at, MULT_N);
    check_int("b2b_done_pulses", ndone, 2);

    // Overrun is sticky until reset.
    md_start_E = 1; md_is_div_E = 0;
    step();
    step();
    md_start_E = 0;
    check("ovr_set", md_overrun, 1'b1);
    for (int i = 0; i < 12; i++) step();
    check("ovr_sticky", md_overrun, 1'b1);
    do_reset();
    check("ovr_cleared", md_overrun, 1'b0);

    // Reset in the 10th BUSY cycle of a divide.
    md_start_E = 1; md_is_div_E = 1;
    step();
    md_start_E = 0;
    for (int i = 0; i < 9; i++) step();
    check("pre_abort_busy", md_busy, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("abort_busy_now", md_busy, 1'b0);
    step();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (md_done) ndone++;
      step();
    end
    check_int("abort_no_done", ndone, 0);
    md_start_E = 1; md_is_div_E = 1;
    step();
    md_start_E = 0;
    nbusy = 0;
    for (int i = 0; i < 36; i++) begin
      if (md_busy) nbusy++;
      step();
    end
    check_int("after_abort_full", nbusy, DIV_N);

    // Randomised traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rs_D = 5'($urandom_range(0, 5)); rt_D = 5'($urandom_range(0, 5));
      reg_write_addr_E = 5'($urandom_range(0, 5));
      reg_write_addr_M = 5'($urandom_range(0, 5));
      Branch_D = 1'($urandom); branch_taken_D = 1'($urandom); Jump_D = ($urandom % 4) == 0;
      hilo_use_D = 1'($urandom);
      RegWrite_E = 1'($urandom); MemtoReg_E = 1'($urandom); MemtoReg_M = 1'($urandom);
      md_start_E = ($urandom % 10) == 0; md_is_div_E = ($urandom % 4) == 0;
      rst_n = ($urandom % 150) != 0;
      if (!rst_n) model_reset();
      step();
      rst_n = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
